stall_skid_buffer: RTL
======================

Name: stall_skid_buffer

Overview:
- Inter-stage elastic buffer for the global-stall pipeline, on the producer side of the stall manager.
- Absorbs words from the upstream stage and releases them downstream unless the downstream stage holds it.
- Drives `to_stall_mgmt`, the buffer-near-full indication, which the stall manager combines with its own stall input and registers one cycle later.
- Provides enough headroom that words still in flight during that registration delay are never lost.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries. Must be a power of 2 and ≥ SLACK+1.
- SLACK, 2, entries held in reserve for words already in flight. Covers the 1-cycle stall manager register plus 1 word already launched upstream.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a word this cycle. There is no ready back-pressure; stalling happens only through the stall manager.
- in_data  input  WIDTH  upstream word.
- drain_stall  input  1  downstream cannot take a word this cycle.
- out_valid  output  1  out_data is valid and is consumed this cycle.
- out_data  output  WIDTH  head-of-buffer word.
- to_stall_mgmt  output  1  buffer near full; goes to the stall manager.
- occupancy  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH.
- overflow_err  output  1  sticky: a word was dropped.

Behaviour:
- Reset: clk and reset are as stated above. reset_n low asynchronously clears:
  - read/write pointers and occupancy to 0;
  - overflow_err to 0.
  - Storage contents are don't-care.
  - Consequently out_valid=0 and to_stall_mgmt=0 during and right after reset.
  - Reset mid-operation discards all stored words; no partial state survives.
- Storage: circular buffer of DEPTH entries.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by a separate counter.
- Pop:
  - pop = out_valid = (occupancy != 0) && !drain_stall. This is combinational from registered state plus drain_stall.
  - out_data = mem[rd_ptr]. It is valid whenever occupancy != 0, even while drain_stall is high.
  - On pop, rd_ptr advances by 1.
- Push:
  - push_ok = in_valid && (occupancy < DEPTH || pop).
  - On push_ok, mem[wr_ptr] <= in_data and wr_ptr advances by 1.
- Occupancy update:
  - push_ok && !pop: +1.
  - pop && !push_ok: −1.
  - Both or neither: unchanged.
  - Occupancy never exceeds DEPTH and never underflows.
- Latency: no fall-through. A word pushed into an empty buffer appears on out_valid the next cycle at the earliest. Minimum latency is 1 cycle.
- Ordering: strict FIFO.
- Simultaneous push and pop when full: allowed. The popped slot is reused and occupancy stays DEPTH.
- Simultaneous push and pop when empty: the pop is not possible (out_valid=0). The push is stored and occupancy becomes 1.
- Overflow: in_valid && occupancy==DEPTH && !pop.
  - The word is dropped and pointers are unchanged.
  - overflow_err <= 1 and stays high until reset.
- to_stall_mgmt = (occupancy >= DEPTH-SLACK). It is combinational from the registered occupancy, so it stays glitch-free relative to the stall manager's register.
- Headroom guarantee: with SLACK ≥ 2, a correctly stalled upstream (stalled one cycle after the stall manager samples to_stall_mgmt) never triggers overflow_err.
- The buffer does not look at the upstream stall; to_stall_mgmt deasserts as soon as occupancy drops below the threshold.

Test Plan (DEPTH=4, SLACK=2, WIDTH=8):
- Reset sequence: hold reset_n=0 with in_valid=1 → occupancy=0, out_valid=0, to_stall_mgmt=0, overflow_err=0. Release reset → the first push (0x11) gives out_valid=1, out_data=0x11 one cycle later.
- Streaming: drain_stall=0, push 0x01..0x08 on consecutive cycles → out_data 0x01..0x08 in order, each 1 cycle after its push. occupancy stays ≤1 and to_stall_mgmt stays 0.
- Fill to threshold: drain_stall=1, push 0xA0, 0xA1 → occupancy=2 and to_stall_mgmt=1. Push 0xA2, 0xA3 → occupancy=4 and overflow_err stays 0. Release drain_stall → pops 0xA0..0xA3 in order, and to_stall_mgmt drops once occupancy reaches 1.
- Overflow: with occupancy=4, drain_stall=1, push 0xFF → occupancy stays 4 and overflow_err=1 (sticky). Drain → 0xFF is never emitted.
- Full push+pop: with occupancy=4, drain_stall=0, in_valid=1 with data 0x55 → occupancy stays 4, head pops, 0x55 is emitted after the 3 older words. Pointer wrap is exercised over ≥2 full laps.
- Mid-operation reset: with occupancy=3, pulse reset_n low for half a cycle (asynchronous) → occupancy=0 and out_valid=0 immediately. Old data is never emitted.

Source files
------------

// File: rtl/stall_skid_buffer.sv
// Elastic buffer between pipeline stages with near-full stall request
// and reserved headroom for words still in flight.
module stall_skid_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       drain_stall,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       to_stall_mgmt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR  = CW'(DEPTH - SLACK);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             push_ok;

  assign pop     = (occ_q != '0) && !drain_stall;
  assign push_ok = in_valid && ((occ_q < FULL) || pop);

  assign out_valid     = pop;
  assign out_data      = mem_q[rd_ptr_q];
  assign to_stall_mgmt = (occ_q >= THR);
  assign occupancy     = occ_q;
  assign overflow_err  = ovf_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    // A word that finds the buffer full with nothing leaving is lost.
    if (in_valid && !push_ok) ovf_d = 1'b1;
    unique case (1'b1)
      push_ok && !pop: occ_d = occ_q + 1'b1;
      pop && !push_ok: occ_d = occ_q - 1'b1;
      default:         occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
